// File: rtl/mole_pkg.sv
// -----------------------------------------------------------------------------
// mole_pkg
// Shared types and constants for the whack-a-mole round scheduler.
//   state_t   : scheduler FSM states (IDLE, STEP, SPAWN, HOLD, GAP)
//   NUM_CELLS : number of mole cells (one-hot spawn width)
//   hold_len  : maps a difficulty level to its hit-window length in cycles
// -----------------------------------------------------------------------------
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SPAWN,
    HOLD,
    GAP
  } state_t;

  localparam int NUM_CELLS = 16;
  localparam int ADDR_W    = 4;
  localparam int LEVEL_W   = 2;
  localparam int PHASE_W   = 4;
  localparam int STREAK_W  = 3;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd2;

  // Window length for a level; levels above 1 share the shortest window.
  function automatic logic [PHASE_W-1:0] hold_len(input logic [LEVEL_W-1:0] lvl,
                                                  input int h0,
                                                  input int h1,
                                                  input int h2);
    case (lvl)
      2'd0:    return PHASE_W'(h0);
      2'd1:    return PHASE_W'(h1);
      default: return PHASE_W'(h2);
    endcase
  endfunction

endpackage

// File: rtl/decoder_4_to_16.sv
// -----------------------------------------------------------------------------
// decoder_4_to_16
// Enabled 4-to-16 one-hot decoder used to drive the mole cell spawn inputs.
//   en     : when low the output is all zeros
//   addr   : cell index to select
//   onehot : one-hot cell select
// -----------------------------------------------------------------------------
module decoder_4_to_16
  import mole_pkg::*;
(
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_CELLS-1:0] onehot
);

  // NOTE: onehot gets a full default before the conditional write, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
// Splits each game second into a fixed TICK_CYCLES round: steps the address
// generators, pulses the spawn lines, times the hit window, and adapts the
// window length to a difficulty level driven by the player's hit streak.
//   Clk, Set            : clock, synchronous active-high reset
//   game_run            : game countdown running
//   good_addr, bad_addr : generator addresses
//   hit_good, hit_bad   : one-cycle hit pulses from the cells
//   gen_step            : one-cycle generator advance pulse
//   good_spawn/bad_spawn: one-hot one-cycle spawn pulses
//   spawn_window        : high while hits are accepted
//   level, streak       : difficulty level and consecutive good hits
// -----------------------------------------------------------------------------
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int TICK_CYCLES   = 10,
  parameter int HOLD_L0       = 8,
  parameter int HOLD_L1       = 6,
  parameter int HOLD_L2       = 4,
  parameter int LEVEL_UP_HITS = 4
) (
  input  logic                 Clk,
  input  logic                 Set,
  input  logic                 game_run,
  input  logic [ADDR_W-1:0]    good_addr,
  input  logic [ADDR_W-1:0]    bad_addr,
  input  logic                 hit_good,
  input  logic                 hit_bad,
  output logic                 gen_step,
  output logic [NUM_CELLS-1:0] good_spawn,
  output logic [NUM_CELLS-1:0] bad_spawn,
  output logic                 spawn_window,
  output logic [LEVEL_W-1:0]   level,
  output logic [STREAK_W-1:0]  streak
);

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   hold_last_q, hold_last_d;  // last HOLD phase this round
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;

  logic last_phase;
  logic hold_done;
  logic good_only;
  logic spawn_en;

  assign last_phase = (phase_q == PHASE_W'(TICK_CYCLES - 1));
  assign hold_done  = hit_good | hit_bad | (phase_q == hold_last_q);
  // Simultaneous hits score as a bad hit; a miss scores the same way.
  assign good_only  = hit_good & ~hit_bad;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge Clk) begin
    if (Set) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      hold_last_q <= '0;
      level_q     <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hold_last_q <= hold_last_d;
      level_q     <= level_d;
      streak_q    <= streak_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hold_last_d = hold_last_q;
    level_d     = level_q;
    streak_d    = streak_q;

    if (state_q == IDLE) begin
      if (game_run) begin
        state_d  = STEP;
        phase_d  = '0;
        level_d  = '0;
        streak_d = '0;
      end
    end else if (!game_run) begin
      // Abort wins over any hit in the same cycle; level/streak are kept.
      state_d = IDLE;
      phase_d = '0;
    end else begin
      // Phase free-runs so the round period never depends on hits.
      phase_d = last_phase ? '0 : phase_q + 1'b1;
      unique case (state_q)
        STEP:  state_d = SPAWN;
        SPAWN: begin
          state_d     = HOLD;
          hold_last_d = PHASE_W'(1) + hold_len(level_q, HOLD_L0, HOLD_L1, HOLD_L2);
        end
        HOLD: begin
          if (hold_done) begin
            state_d  = last_phase ? STEP : GAP;
            streak_d = '0;
            if (good_only) begin
              if (streak_q + 3'd1 == STREAK_W'(LEVEL_UP_HITS)) begin
                if (level_q != LEVEL_MAX) level_d = level_q + 1'b1;
              end else begin
                streak_d = streak_q + 3'd1;
              end
            end else if (level_q != '0) begin
              level_d = level_q - 1'b1;
            end
          end
        end
        GAP:     if (last_phase) state_d = STEP;
        default: state_d = IDLE;
      endcase
    end
  end

  assign gen_step     = (state_q == STEP);
  assign spawn_window = (state_q == HOLD);
  assign spawn_en     = (state_q == SPAWN);
  assign level        = level_q;
  assign streak       = streak_q;

  decoder_4_to_16 u_good_dec (
    .en     (spawn_en),
    .addr   (good_addr),
    .onehot (good_spawn)
  );

  // A bad mole on the same cell as the good one is suppressed.
  decoder_4_to_16 u_bad_dec (
    .en     (spawn_en && (good_addr != bad_addr)),
    .addr   (bad_addr),
    .onehot (bad_spawn)
  );

endmodule

// File: tb/tb_mole_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mole_scheduler
// Directed and randomized stimulus for mole_scheduler. A round-position model
// (game running flag, position within the second, window-closed flag, level,
// streak) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mole_scheduler;

  localparam int TICK = 10;
  localparam int LUP  = 4;

  logic        Clk;
  logic        Set;
  logic        game_run;
  logic [3:0]  good_addr;
  logic [3:0]  bad_addr;
  logic        hit_good;
  logic        hit_bad;
  logic        gen_step;
  logic [15:0] good_spawn;
  logic [15:0] bad_spawn;
  logic        spawn_window;
  logic [1:0]  level;
  logic [2:0]  streak;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: position within the current second.
  bit m_run    = 0;
  int m_pos    = 0;
  bit m_closed = 0;
  int m_hold   = 0;
  int m_level  = 0;
  int m_streak = 0;
  int hold_tab[3] = '{8, 6, 4};

  bit rand_addr = 0;

  mole_scheduler #(
    .TICK_CYCLES   (TICK),
    .HOLD_L0       (8),
    .HOLD_L1       (6),
    .HOLD_L2       (4),
    .LEVEL_UP_HITS (LUP)
  ) dut (
    .Clk          (Clk),
    .Set          (Set),
    .game_run     (game_run),
    .good_addr    (good_addr),
    .bad_addr     (bad_addr),
    .hit_good     (hit_good),
    .hit_bad      (hit_bad),
    .gen_step     (gen_step),
    .good_spawn   (good_spawn),
    .bad_spawn    (bad_spawn),
    .spawn_window (spawn_window),
    .level        (level),
    .streak       (streak)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs sampled there.
  task automatic model_edge();
    bit win_open;
    win_open = m_run && m_pos >= 2 && m_pos <= 1 + m_hold && !m_closed;
    if (Set) begin
      m_run = 0; m_pos = 0; m_closed = 0; m_level = 0; m_streak = 0;
    end else if (!m_run) begin
      if (game_run) begin
        m_run = 1; m_pos = 0; m_closed = 0; m_level = 0; m_streak = 0;
      end
    end else if (!game_run) begin
      m_run = 0; m_pos = 0;
    end else begin
      if (win_open && (hit_good || hit_bad || m_pos == 1 + m_hold)) begin
        m_closed = 1;
        if (hit_good && !hit_bad) begin
          if (m_streak + 1 == LUP) begin
            m_streak = 0;
            if (m_level < 2) m_level++;
          end else begin
            m_streak++;
          end
        end else begin
          m_streak = 0;
          if (m_level > 0) m_level--;
        end
      end
      if (m_pos == 1) m_hold = hold_tab[m_level];
      m_pos = (m_pos + 1) % TICK;
      if (m_pos == 0) m_closed = 0;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_gs, exp_bs;
    bit          spawning;
    spawning = m_run && m_pos == 1;
    exp_gs = spawning ? (16'h0001 << good_addr) : 16'h0000;
    exp_bs = (spawning && bad_addr != good_addr) ? (16'h0001 << bad_addr) : 16'h0000;
    check("gen_step", 32'(gen_step), 32'(m_run && m_pos == 0));
    check("good_spawn", 32'(good_spawn), 32'(exp_gs));
    check("bad_spawn", 32'(bad_spawn), 32'(exp_bs));
    check("spawn_window", 32'(spawn_window),
          32'(m_run && m_pos >= 2 && m_pos <= 1 + m_hold && !m_closed));
    check("level", 32'(level), 32'(m_level));
    check("streak", 32'(streak), 32'(m_streak));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs();
    hit_good = 1'b0;
    hit_bad  = 1'b0;
    if (rand_addr) begin
      good_addr = 4'($urandom_range(0, 15));
      bad_addr  = ($urandom_range(0, 3) == 0) ? good_addr : 4'($urandom_range(0, 15));
    end
  endtask

  // Run until the model says the current cycle is at round position p.
  task automatic run_to_pos(input int p);
    int guard;
    guard = 0;
    while (!m_run || m_pos != p) begin
      tick();
      guard++;
      if (guard > 4 * TICK) begin
        n_vec++;
        n_err++;
        $error("FAIL run_to_pos: observed timeout, expected position %0d", p);
        return;
      end
    end
  endtask

  // Play the next round, hitting once at a random phase inside the window.
  task automatic hit_round(input bit g, input bit b);
    int p;
    run_to_pos(1);
    p = 2 + $urandom_range(0, hold_tab[m_level] - 1);
    run_to_pos(p);
    hit_good = g;
    hit_bad  = b;
    tick();
  endtask

  initial begin
    int w;
    Set = 1'b1; game_run = 1'b1; good_addr = 4'd0; bad_addr = 4'd0;
    hit_good = 1'b0; hit_bad = 1'b0;

    // Reset held with game_run high.
    repeat (3) tick();
    check("reset_level", 32'(level), 32'd0);
    check("reset_gen_step", 32'(gen_step), 32'd0);
    Set = 1'b0;
    tick();
    check("release_gen_step", 32'(gen_step), 32'd1);

    // Clean start from IDLE.
    game_run = 1'b0;
    repeat (2) tick();
    good_addr = 4'd3; bad_addr = 4'd7; game_run = 1'b1;
    tick();
    check("start_gen_step", 32'(gen_step), 32'd1);
    tick();
    check("start_good_spawn", 32'(good_spawn), 32'h0008);
    check("start_bad_spawn", 32'(bad_spawn), 32'h0080);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("start_window", 32'(spawn_window), 32'd1);
    end
    tick();
    check("next_gen_step", 32'(gen_step), 32'd1);
    check("window_closed", 32'(spawn_window), 32'd0);

    // Collision on the same cell.
    good_addr = 4'd5; bad_addr = 4'd5;
    tick();
    check("collide_good", 32'(good_spawn), 32'h0020);
    check("collide_bad", 32'(bad_spawn), 32'h0000);
    run_to_pos(0);

    // Level progression.
    rand_addr = 1;
    repeat (4) hit_round(1'b1, 1'b0);
    check("lvl1_level", 32'(level), 32'd1);
    check("lvl1_streak", 32'(streak), 32'd0);
    repeat (8) hit_round(1'b1, 1'b0);
    check("lvl2_level", 32'(level), 32'd2);
    repeat (4) hit_round(1'b1, 1'b0);
    check("lvl2_sat", 32'(level), 32'd2);

    // Penalties: bad hit, simultaneous hits, full miss.
    hit_round(1'b0, 1'b1);
    check("bad_hit_level", 32'(level), 32'd1);
    hit_round(1'b1, 1'b1);
    check("both_hit_level", 32'(level), 32'd0);
    check("both_hit_streak", 32'(streak), 32'd0);
    check("both_hit_window", 32'(spawn_window), 32'd0);
    repeat (4) hit_round(1'b1, 1'b0);
    run_to_pos(1);
    w = 0;
    for (int i = 0; i < TICK - 1; i++) begin
      tick();
      if (spawn_window) w++;
    end
    check("miss_window_len", 32'(w), 32'd6);
    check("miss_level", 32'(level), 32'd0);
    check("miss_gen_step", 32'(gen_step), 32'd1);

    // Abort mid-HOLD.
    repeat (5) hit_round(1'b1, 1'b0);
    run_to_pos(1);
    run_to_pos(4);
    game_run = 1'b0;
    tick();
    check("abort_window", 32'(spawn_window), 32'd0);
    check("abort_level", 32'(level), 32'd1);
    check("abort_streak", 32'(streak), 32'd1);
    repeat (2 * TICK) tick();
    game_run = 1'b1;
    tick();
    check("restart_level", 32'(level), 32'd0);
    check("restart_gen_step", 32'(gen_step), 32'd1);

    // Randomized play: sporadic hits anywhere, aborts and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) game_run = ~game_run;
      Set      = ($urandom_range(0, 149) == 0);
      hit_good = ($urandom_range(0, 5) == 0);
      hit_bad  = ($urandom_range(0, 7) == 0);
      tick();
    end
    Set = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round scheduler for the whack-a-mole game. It splits each game second into a fixed-length round. In every round it advances the good and bad address generators, issues one-cycle spawn pulses to the mole cells, and times the hit window. It also adapts the window length to a difficulty level driven by the player's hit/miss streak. It sits between the game controller (which supplies `game_run`) and the Generator / Mole_Cell array.

## Interface
- `TICK_CYCLES`, 10: clocks per round (one game second); legal range 4..15.
- `HOLD_L0`, 8: hit-window length in cycles at level 0; must be ≤ TICK_CYCLES-2.
- `HOLD_L1`, 6: hit-window length at level 1.
- `HOLD_L2`, 4: hit-window length at level 2.
- `LEVEL_UP_HITS`, 4: consecutive good hits needed to raise the level.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Set`  in  1  reset; synchronous, active-high.
- `game_run`  in  1  high while the game countdown is running.
- `good_addr`  in  4  good-mole address from the good Generator.
- `bad_addr`  in  4  bad-mole address from the bad Generator.
- `hit_good`  in  1  one-cycle pulse: player hit the active good mole.
- `hit_bad`  in  1  one-cycle pulse: player hit the active bad mole.
- `gen_step`  out  1  one-cycle pulse that advances both Generators.
- `good_spawn`  out  16  one-hot spawn pulse to the good_signal inputs of the cells.
- `bad_spawn`  out  16  one-hot spawn pulse to the bad_signal inputs of the cells.
- `spawn_window`  out  1  high while hits are accepted.
- `level`  out  2  current difficulty level, 0..2.
- `streak`  out  3  consecutive good hits at the current level.

## Operation
- FSM states:
  - IDLE: waiting for `game_run`.
  - STEP: `gen_step`=1.
  - SPAWN: `good_spawn`=onehot(`good_addr`); `bad_spawn`=onehot(`bad_addr`).
  - HOLD: `spawn_window`=1.
  - GAP: idle until the round boundary.
- Phase counter runs 0..TICK_CYCLES-1 in every non-IDLE state. STEP is always phase 0 and SPAWN is always phase 1.
- HOLD length H = HOLD_L[level], with `level` sampled on entry to HOLD. HOLD covers phases 2..1+H.
- HOLD exit:
  - A hit, or the end of phase 1+H, ends HOLD.
  - If the exit phase is TICK_CYCLES-1, the next state is STEP; otherwise it is GAP.
  - GAP goes to STEP at the end of phase TICK_CYCLES-1.
- Round period is exactly TICK_CYCLES cycles, independent of hits.
- Collision: if `bad_addr`==`good_addr` in SPAWN, `bad_spawn`=0 and `good_spawn` is issued normally.
- Hit scoring (applies in HOLD only):
  - `hit_good`: `streak`+1. When it reaches LEVEL_UP_HITS, `level`+1 (saturating at 2) and `streak`=0.
  - `hit_bad`: `level`-1 (saturating at 0) and `streak`=0.
  - `hit_good` and `hit_bad` in the same cycle: treated as `hit_bad`.
  - Miss (HOLD expires with no hit): same as `hit_bad`.
- Hits in IDLE, STEP, SPAWN or GAP are ignored with no state change.
- IDLE with `game_run`=1: `level` and `streak` clear and the FSM moves to STEP.
- `game_run`=0 in any non-IDLE state: the FSM moves to IDLE on the next edge. `level` and `streak` hold their values until the next game start.

## Timing
- Reset (`Set`=1) at an edge forces all of the following to 0 on that edge: state=IDLE, phase, `gen_step`, `good_spawn`, `bad_spawn`, `spawn_window`, `level`, `streak`. Reset mid-round behaves the same.
- `game_run` is sampled high in IDLE at edge t:
  - `gen_step`=1 during cycle t+1.
  - Generator outputs are valid in cycle t+2, where the spawn pulses are asserted.
  - `spawn_window` is high from t+3.
- Spawn and `gen_step` outputs are decoded from the registered state (Moore), are never combinationally dependent on hits, and last exactly one cycle.
- `level` and `streak` update on the edge that samples the hit or the miss.
- A hit in HOLD phase p gives `spawn_window`=0 from phase p+1.

## Structure
- `mole_pkg`:
  - state enum: IDLE, STEP, SPAWN, HOLD, GAP.
  - `NUM_CELLS`=16.
  - level width = 2.
  - a function mapping level to hold length.
- Sub-module: two Decoder_4_to_16 instances produce the one-hot `good_spawn` and `bad_spawn`. Each instance is enabled by (state==SPAWN); the bad instance is also gated by (no collision).

## Test plan
- Reset: `Set`=1 for 3 cycles while `game_run`=1 → all outputs 0, `level`=0; after release the FSM starts with `gen_step` one cycle later.
- Start: `game_run` rises and is sampled at edge t, with `good_addr`=3 → `gen_step` in cycle t+1; `good_spawn`=16'h0008 in t+2; `spawn_window` high t+3..t+10; next `gen_step` in t+11.
- Collision: `good_addr`=5, `bad_addr`=5 → `good_spawn`=16'h0020, `bad_spawn`=16'h0000.
- Level progression:
  - 4 `hit_good` in 4 rounds → `level`=1, `streak`=0, window 6 cycles.
  - 8 more → `level`=2.
  - 4 more → `level` stays 2.
- Penalty:
  - At `level`=1, `hit_good` and `hit_bad` in the same HOLD cycle → `level`=0, `streak`=0, window closes next cycle, next `gen_step` still exactly 10 cycles after the previous one.
  - No hit for a full round → the same penalty.
- Abort: `game_run` falls in HOLD phase 4 → IDLE next cycle, `spawn_window`=0, no further `gen_step`; `level` retained until the next start, where it clears.
